// File: rtl/cv32e40p_perm_fault_detector_ft.sv
// Permanent-fault detector for the replicated EX stage (4 ALUs, 3 MULTs).
// Each replica keeps a saturating mismatch counter and a HEALTHY/SUSPECT/FAULTY
// health FSM. FAULTY is sticky until rst or clear_i.
// Optional build macro CV32E40P_PERM_FAULT_DECAY_EN: suspect counters decay by one
// after DECAY_PERIOD consecutive clean ops of the same unit type.
module cv32e40p_perm_fault_detector_ft #(
  parameter int ALU_THRESHOLD  = 4,
  parameter int MULT_THRESHOLD = 4,
  parameter int CNT_W          = 4,
  parameter int DECAY_PERIOD   = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       clear_i,
  input  logic       valid_i,
  input  logic       alu_used_i,
  input  logic       mult_used_i,
  input  logic [3:0] alu_err_i,
  input  logic [2:0] mult_err_i,
  output logic [3:0] permanent_faulty_alu_o,
  output logic [2:0] permanent_faulty_mult_o,
  output logic [3:0] alu_suspect_o,
  output logic [2:0] mult_suspect_o,
  output logic       fault_event_o
);

  localparam int N_ALU  = 4;
  localparam int N_MULT = 3;
  localparam int N_REP  = N_ALU + N_MULT;

  typedef enum logic [1:0] {
    ST_HEALTHY = 2'd0,
    ST_SUSPECT = 2'd1,
    ST_FAULTY  = 2'd2
  } health_e;

  // Elaboration-time sanity check of the configuration.
  if (ALU_THRESHOLD < 1 || ALU_THRESHOLD >= (1 << CNT_W) ||
      MULT_THRESHOLD < 1 || MULT_THRESHOLD >= (1 << CNT_W) ||
      DECAY_PERIOD < 1) begin : g_param_check
    $error("cv32e40p_perm_fault_detector_ft: illegal parameter combination");
  end

  logic clr;
  logic alu_active;
  logic mult_active;
  logic [N_REP-1:0] err_vec;
  logic [N_REP-1:0] faulty_vec;
  logic [N_REP-1:0] suspect_vec;
  logic [N_REP-1:0] count_ev;
  logic [N_REP-1:0] to_faulty;
  logic [1:0]       type_decay;   // [0] ALU, [1] MULT
  logic             fault_event_reg;

  assign clr = rst | clear_i;

  // The ALU path has priority when both units report use in the same op,
  // matching the dispatcher. Gating by valid_i first keeps X on idle err
  // inputs out of the state.
  assign alu_active  = valid_i & alu_used_i;
  assign mult_active = valid_i & mult_used_i & ~alu_used_i;

  // Replicas 0..3 are ALUs, 4..6 are MULTs.
  assign err_vec  = {mult_err_i & {N_MULT{mult_active}}, alu_err_i & {N_ALU{alu_active}}};
  assign count_ev = err_vec & ~faulty_vec;

  genvar gi;
  generate
    for (gi = 0; gi < N_REP; gi++) begin : g_rep
      localparam int THR = (gi < N_ALU) ? ALU_THRESHOLD : MULT_THRESHOLD;

      health_e          state_reg, state_next;
      logic [CNT_W-1:0] cnt_reg, cnt_next;
      logic             become_faulty;
      logic             decay;

      assign decay = (gi < N_ALU) ? type_decay[0] : type_decay[1];

      // Health state and error counter registers.
      always_ff @(posedge clk) begin
        if (clr) begin
          state_reg <= ST_HEALTHY;
          cnt_reg   <= '0;
        end else begin
          state_reg <= state_next;
          cnt_reg   <= cnt_next;
        end
      end

      // Next-state: count mismatches up to the threshold, optionally decay suspects.
      always_comb begin
        state_next    = state_reg;
        cnt_next      = cnt_reg;
        become_faulty = 1'b0;
        if (count_ev[gi]) begin
          if (({1'b0, cnt_reg} + (CNT_W+1)'(1)) == (CNT_W+1)'(THR)) begin
            state_next    = ST_FAULTY;
            cnt_next      = CNT_W'(THR);
            become_faulty = 1'b1;
          end else begin
            state_next = ST_SUSPECT;
            cnt_next   = cnt_reg + CNT_W'(1);
          end
        end else if (decay && state_reg == ST_SUSPECT) begin
          cnt_next = cnt_reg - CNT_W'(1);
          if (cnt_reg == CNT_W'(1)) begin
            state_next = ST_HEALTHY;
          end
        end
      end

      assign faulty_vec[gi]  = (state_reg == ST_FAULTY);
      assign suspect_vec[gi] = (state_reg == ST_SUSPECT);
      assign to_faulty[gi]   = become_faulty;
    end
  endgenerate

`ifdef CV32E40P_PERM_FAULT_DECAY_EN
  localparam int CLEAN_W = $clog2(DECAY_PERIOD + 1);

  logic [1:0] type_active;
  logic [1:0] type_err;

  assign type_active = {mult_active, alu_active};
  assign type_err    = {|count_ev[N_REP-1:N_ALU], |count_ev[N_ALU-1:0]};

  generate
    for (gi = 0; gi < 2; gi++) begin : g_decay
      logic [CLEAN_W-1:0] clean_reg, clean_next;
      logic               decay_now;

      // Clean-op run-length counter for one unit type.
      always_ff @(posedge clk) begin
        if (clr) begin
          clean_reg <= '0;
        end else begin
          clean_reg <= clean_next;
        end
      end

      // Restart on any counted error; wrap to zero and fire a decay on reaching the period.
      always_comb begin
        clean_next = clean_reg;
        decay_now  = 1'b0;
        if (type_err[gi]) begin
          clean_next = '0;
        end else if (type_active[gi]) begin
          if (clean_reg == CLEAN_W'(DECAY_PERIOD - 1)) begin
            clean_next = '0;
            decay_now  = 1'b1;
          end else begin
            clean_next = clean_reg + CLEAN_W'(1);
          end
        end
      end

      assign type_decay[gi] = decay_now;
    end
  endgenerate
`else
  // Without decay, suspect counters only clear through rst/clear_i.
  assign type_decay = 2'b00;
`endif

  // One-cycle pulse aligned with the first cycle a new FAULTY flag is visible.
  always_ff @(posedge clk) begin
    if (clr) begin
      fault_event_reg <= 1'b0;
    end else begin
      fault_event_reg <= |to_faulty;
    end
  end

  assign permanent_faulty_alu_o  = faulty_vec[N_ALU-1:0];
  assign permanent_faulty_mult_o = faulty_vec[N_REP-1:N_ALU];
  assign alu_suspect_o           = suspect_vec[N_ALU-1:0];
  assign mult_suspect_o          = suspect_vec[N_REP-1:N_ALU];
  assign fault_event_o           = fault_event_reg;

endmodule

// File: tb/tb_cv32e40p_perm_fault_detector_ft.sv
// Self-checking bench for cv32e40p_perm_fault_detector_ft: directed vector table,
// a decay sequence, then randomized traffic checked against a counting model.
module tb_cv32e40p_perm_fault_detector_ft;

  localparam int ATHR = 4;
  localparam int MTHR = 4;
  localparam int DP   = 16;
`ifdef CV32E40P_PERM_FAULT_DECAY_EN
  localparam bit DECAY = 1'b1;
`else
  localparam bit DECAY = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst, clear_i, valid_i, alu_used_i, mult_used_i;
  logic [3:0] alu_err_i;
  logic [2:0] mult_err_i;
  logic [3:0] permanent_faulty_alu_o, alu_suspect_o;
  logic [2:0] permanent_faulty_mult_o, mult_suspect_o;
  logic       fault_event_o;

  int total = 0;
  int bad   = 0;

  cv32e40p_perm_fault_detector_ft #(
    .ALU_THRESHOLD(ATHR), .MULT_THRESHOLD(MTHR), .CNT_W(4), .DECAY_PERIOD(DP)
  ) dut (
    .clk(clk), .rst(rst), .clear_i(clear_i), .valid_i(valid_i),
    .alu_used_i(alu_used_i), .mult_used_i(mult_used_i),
    .alu_err_i(alu_err_i), .mult_err_i(mult_err_i),
    .permanent_faulty_alu_o(permanent_faulty_alu_o),
    .permanent_faulty_mult_o(permanent_faulty_mult_o),
    .alu_suspect_o(alu_suspect_o), .mult_suspect_o(mult_suspect_o),
    .fault_event_o(fault_event_o)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       r, c, v, au, mu;
    logic [3:0] ae;
    logic [2:0] me;
    logic [3:0] x_fa, x_sa;
    logic [2:0] x_fm, x_sm;
    logic       x_ev;
  } vec_t;

  vec_t tbl[$];

  // Reference model: plain per-replica mismatch tallies and fault flags.
  int m_acnt[4];
  int m_mcnt[3];
  bit m_af[4];
  bit m_mf[3];
  int m_aclean, m_mclean;
  bit m_ev;

  task automatic add(input logic r, c, v, au, mu, input logic [3:0] ae, input logic [2:0] me,
                     input logic [3:0] fa, input logic [2:0] fm,
                     input logic [3:0] sa, input logic [2:0] sm, input logic ev);
    vec_t t;
    t.r = r; t.c = c; t.v = v; t.au = au; t.mu = mu; t.ae = ae; t.me = me;
    t.x_fa = fa; t.x_fm = fm; t.x_sa = sa; t.x_sm = sm; t.x_ev = ev;
    tbl.push_back(t);
  endtask

  task automatic check(input string nm, input logic [7:0] act, input logic [7:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s got=%b want=%b", nm, act, exp);
    end
  endtask

  task automatic model_step(input logic r, c, v, au, mu, input logic [3:0] ae, input logic [2:0] me);
    int errs;
    m_ev = 1'b0;
    if (r || c) begin
      for (int i = 0; i < 4; i++) begin m_acnt[i] = 0; m_af[i] = 1'b0; end
      for (int i = 0; i < 3; i++) begin m_mcnt[i] = 0; m_mf[i] = 1'b0; end
      m_aclean = 0;
      m_mclean = 0;
      return;
    end
    if (v === 1'b1 && au === 1'b1) begin
      errs = 0;
      for (int i = 0; i < 4; i++) begin
        if (ae[i] === 1'b1 && !m_af[i]) begin
          errs++;
          m_acnt[i]++;
          if (m_acnt[i] == ATHR) begin m_af[i] = 1'b1; m_ev = 1'b1; end
        end
      end
      if (DECAY) begin
        if (errs > 0) m_aclean = 0;
        else begin
          m_aclean++;
          if (m_aclean == DP) begin
            m_aclean = 0;
            for (int i = 0; i < 4; i++) if (!m_af[i] && m_acnt[i] > 0) m_acnt[i]--;
          end
        end
      end
    end else if (v === 1'b1 && mu === 1'b1) begin
      errs = 0;
      for (int i = 0; i < 3; i++) begin
        if (me[i] === 1'b1 && !m_mf[i]) begin
          errs++;
          m_mcnt[i]++;
          if (m_mcnt[i] == MTHR) begin m_mf[i] = 1'b1; m_ev = 1'b1; end
        end
      end
      if (DECAY) begin
        if (errs > 0) m_mclean = 0;
        else begin
          m_mclean++;
          if (m_mclean == DP) begin
            m_mclean = 0;
            for (int i = 0; i < 3; i++) if (!m_mf[i] && m_mcnt[i] > 0) m_mcnt[i]--;
          end
        end
      end
    end
  endtask

  // Drive one op, let it be sampled, then advance the model.
  task automatic drive_cycle(input logic r, c, v, au, mu, input logic [3:0] ae, input logic [2:0] me);
    rst = r; clear_i = c; valid_i = v; alu_used_i = au; mult_used_i = mu;
    alu_err_i = ae; mult_err_i = me;
    @(posedge clk);
    #1;
    model_step(r, c, v, au, mu, ae, me);
  endtask

  initial begin
    logic [3:0] ea, sa_exp;
    logic [2:0] em, sm_exp;
    logic [3:0] fa_exp;
    logic [2:0] fm_exp;
    logic       r, c, v, au, mu;
    logic [3:0] ae;
    logic [2:0] me;
    int         pct;

    rst = 1'b1; clear_i = 1'b0; valid_i = 1'b0; alu_used_i = 1'b0; mult_used_i = 1'b0;
    alu_err_i = '0; mult_err_i = '0;

    // Directed table: reset, idle, ALU fault, masking, MULT fault, clear, reset priority.
    add(1,0,0,0,0, 4'h0, 3'h0,  4'h0, 3'h0, 4'h0, 3'h0, 0);
    for (int k = 0; k < 10; k++) add(0,0,0,0,0, 4'h0, 3'h0,  4'h0, 3'h0, 4'h0, 3'h0, 0);
    add(0,0,0,1,1, 4'hF, 3'h7,  4'h0, 3'h0, 4'h0, 3'h0, 0);
    for (int k = 0; k < 3; k++) add(0,0,1,1,0, 4'b0010, 3'h0,  4'h0, 3'h0, 4'b0010, 3'h0, 0);
    add(0,0,1,1,0, 4'b0010, 3'h0,  4'b0010, 3'h0, 4'h0, 3'h0, 1);
    add(0,0,0,0,0, 4'h0, 3'h0,  4'b0010, 3'h0, 4'h0, 3'h0, 0);
    for (int k = 0; k < 3; k++) add(0,0,1,1,0, 4'b0011, 3'h0,  4'b0010, 3'h0, 4'b0001, 3'h0, 0);
    add(0,0,1,1,0, 4'b0011, 3'h0,  4'b0011, 3'h0, 4'h0, 3'h0, 1);
    for (int k = 0; k < 6; k++) add(0,0,1,1,0, 4'b0011, 3'h0,  4'b0011, 3'h0, 4'h0, 3'h0, 0);
    for (int k = 0; k < 3; k++) add(0,0,1,0,1, 4'h0, 3'b111,  4'b0011, 3'h0, 4'h0, 3'b111, 0);
    add(0,0,1,0,1, 4'h0, 3'b111,  4'b0011, 3'b111, 4'h0, 3'h0, 1);
    add(0,0,1,0,1, 4'h0, 3'b111,  4'b0011, 3'b111, 4'h0, 3'h0, 0);
    add(0,1,1,1,1, 4'hF, 3'h7,  4'h0, 3'h0, 4'h0, 3'h0, 0);
    add(1,0,1,1,0, 4'b0100, 3'h0,  4'h0, 3'h0, 4'h0, 3'h0, 0);
    add(0,0,1,1,1, 4'b0100, 3'b001,  4'h0, 3'h0, 4'b0100, 3'h0, 0);
    add(0,0,0,1,1, 4'bxxxx, 3'bxxx,  4'h0, 3'h0, 4'b0100, 3'h0, 0);
    add(0,0,1,0,0, 4'hF, 3'h7,  4'h0, 3'h0, 4'b0100, 3'h0, 0);
    add(0,0,1,0,1, 4'h0, 3'b001,  4'h0, 3'h0, 4'b0100, 3'b001, 0);
    add(0,1,1,1,0, 4'b0100, 3'h0,  4'h0, 3'h0, 4'h0, 3'h0, 0);

    foreach (tbl[i]) begin
      drive_cycle(tbl[i].r, tbl[i].c, tbl[i].v, tbl[i].au, tbl[i].mu, tbl[i].ae, tbl[i].me);
      $display("vec %0d r=%b c=%b v=%b au=%b mu=%b ae=%b me=%b -> fa=%b fm=%b sa=%b sm=%b ev=%b",
               i, tbl[i].r, tbl[i].c, tbl[i].v, tbl[i].au, tbl[i].mu, tbl[i].ae, tbl[i].me,
               permanent_faulty_alu_o, permanent_faulty_mult_o, alu_suspect_o, mult_suspect_o,
               fault_event_o);
      check($sformatf("vec%0d.faulty_alu", i),  {4'h0, permanent_faulty_alu_o},  {4'h0, tbl[i].x_fa});
      check($sformatf("vec%0d.faulty_mult", i), {5'h0, permanent_faulty_mult_o}, {5'h0, tbl[i].x_fm});
      check($sformatf("vec%0d.suspect_alu", i), {4'h0, alu_suspect_o},           {4'h0, tbl[i].x_sa});
      check($sformatf("vec%0d.suspect_mult", i),{5'h0, mult_suspect_o},          {5'h0, tbl[i].x_sm});
      check($sformatf("vec%0d.fault_event", i), {7'h0, fault_event_o},           {7'h0, tbl[i].x_ev});
    end

    // Decay sequence: two ALU3 errors, then two runs of DP clean ALU ops.
    drive_cycle(0,1,0,0,0, 4'h0, 3'h0);
    drive_cycle(0,0,1,1,0, 4'b1000, 3'h0);
    drive_cycle(0,0,1,1,0, 4'b1000, 3'h0);
    $display("decay: two ALU3 errors -> sa=%b", alu_suspect_o);
    check("decay.after_errors", {4'h0, alu_suspect_o}, 8'h08);
    for (int k = 0; k < DP; k++) drive_cycle(0,0,1,1,0, 4'h0, 3'h0);
    $display("decay: first clean run -> sa=%b fa=%b", alu_suspect_o, permanent_faulty_alu_o);
    check("decay.first_run_suspect", {4'h0, alu_suspect_o}, 8'h08);
    check("decay.first_run_faulty", {4'h0, permanent_faulty_alu_o}, 8'h00);
    for (int k = 0; k < DP - 1; k++) drive_cycle(0,0,1,1,0, 4'h0, 3'h0);
    $display("decay: second run minus one -> sa=%b", alu_suspect_o);
    check("decay.second_run_early", {4'h0, alu_suspect_o}, 8'h08);
    drive_cycle(0,0,1,1,0, 4'h0, 3'h0);
    $display("decay: second clean run -> sa=%b", alu_suspect_o);
    check("decay.second_run_suspect", {4'h0, alu_suspect_o}, DECAY ? 8'h00 : 8'h08);

    // Randomized traffic against the model; error density alternates by phase.
    for (int cyc = 0; cyc < 1500; cyc++) begin
      pct = ((cyc / 200) % 2 == 0) ? 15 : 2;
      r  = ($urandom_range(0, 149) == 0);
      c  = ($urandom_range(0, 149) == 0);
      v  = ($urandom_range(0, 3) != 0);
      au = $urandom_range(0, 1);
      mu = $urandom_range(0, 1);
      for (int i = 0; i < 4; i++) ae[i] = ($urandom_range(0, 99) < pct);
      for (int i = 0; i < 3; i++) me[i] = ($urandom_range(0, 99) < pct);
      if (!v && $urandom_range(0, 3) == 0) begin ae = 'x; me = 'x; end
      drive_cycle(r, c, v, au, mu, ae, me);
      for (int i = 0; i < 4; i++) begin
        fa_exp[i] = m_af[i];
        sa_exp[i] = !m_af[i] && (m_acnt[i] > 0);
      end
      for (int i = 0; i < 3; i++) begin
        fm_exp[i] = m_mf[i];
        sm_exp[i] = !m_mf[i] && (m_mcnt[i] > 0);
      end
      ea = fa_exp; em = fm_exp;
      $display("rnd %0d r=%b c=%b v=%b au=%b mu=%b ae=%b me=%b -> fa=%b fm=%b sa=%b sm=%b ev=%b",
               cyc, r, c, v, au, mu, ae, me, permanent_faulty_alu_o, permanent_faulty_mult_o,
               alu_suspect_o, mult_suspect_o, fault_event_o);
      check($sformatf("rnd%0d.faulty_alu", cyc),   {4'h0, permanent_faulty_alu_o},  {4'h0, ea});
      check($sformatf("rnd%0d.faulty_mult", cyc),  {5'h0, permanent_faulty_mult_o}, {5'h0, em});
      check($sformatf("rnd%0d.suspect_alu", cyc),  {4'h0, alu_suspect_o},           {4'h0, sa_exp});
      check($sformatf("rnd%0d.suspect_mult", cyc), {5'h0, mult_suspect_o},          {5'h0, sm_exp});
      check($sformatf("rnd%0d.fault_event", cyc),  {7'h0, fault_event_o},           {7'h0, m_ev});
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
